// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-side constants, state encoding and PC helper
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetchState_e;

    function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous DEPTH-entry FIFO of {pc, instr} words with flush
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CNTW-1:0]  count
);

    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush   = push && (count != FULL);
    assign doPop    = pop && (count != '0);
    assign headData = mem[rdPtr];

    // Storage carries no reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (doPush && !clear && !rst) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - instruction prefetch buffer with redirect flush and stale-response drain
module fetch_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [CNTW:0]   DEPTH_W = (CNTW + 1)'(DEPTH);
    localparam logic [CNTW-1:0] ONE     = CNTW'(1);

    logic [XLEN-1:0]   fetchPc;
    logic [XLEN-1:0]   rspPc;
    logic [CNTW-1:0]   outstanding;
    logic [CNTW-1:0]   discard;
    logic [CNTW-1:0]   discardLoad;
    logic [CNTW-1:0]   fifoCount;
    logic [CNTW:0]     inFlight;
    logic [2*XLEN-1:0] headData;
    logic              reqFire;
    logic              rspPush;
    logic              rspDrop;
    logic              popFire;
    logic              fifoEmpty;
    fetchState_e       state;
    fetchState_e       stateNext;

    // Buffered plus requested words never exceed DEPTH, so a push always has room.
    assign inFlight      = {1'b0, fifoCount} + {1'b0, outstanding};
    assign mem_req_valid = !rst && !redirect && (inFlight < DEPTH_W);
    assign mem_req_addr  = fetchPc;
    assign reqFire       = mem_req_valid && mem_req_ready;

    assign discardLoad = outstanding - {{(CNTW-1){1'b0}}, mem_rsp_valid};
    assign rspPush     = mem_rsp_valid && !redirect && (discard == '0);
    assign rspDrop     = mem_rsp_valid && !redirect && (discard != '0);

    assign fifoEmpty   = (fifoCount == '0);
    assign instr_valid = !rst && !redirect && !fifoEmpty;
    assign popFire     = instr_valid && instr_ready;
    assign instr       = (rst || fifoEmpty) ? '0 : headData[XLEN-1:0];
    assign instr_pc    = (rst || fifoEmpty) ? '0 : headData[2*XLEN-1:XLEN];

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (rspPush),
        .pushData ({rspPc, mem_rsp_data}),
        .pop      (popFire),
        .headData (headData),
        .count    (fifoCount)
    );

    // A redirect blocks new requests, so outstanding only loses a same-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetchPc     <= redirect_pc;
            rspPc       <= redirect_pc;
            outstanding <= discardLoad;
            discard     <= discardLoad;
        end else begin
            if (reqFire) begin
                fetchPc <= nextPc(fetchPc);
            end
            if (rspPush) begin
                rspPc <= nextPc(rspPc);
            end
            if (rspDrop) begin
                discard <= discard - 1'b1;
            end
            case ({reqFire, mem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (redirect) begin
            stateNext = (discardLoad != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                RUN:     stateNext = RUN;
                DRAIN:   if (mem_rsp_valid && (discard == ONE)) stateNext = RUN;
                default: stateNext = RUN;
            endcase
        end
    end

endmodule
